// File: rtl/seq_serializer.sv
// Purpose: parallel-to-serial source; shifts the low L bits of a captured word out MSB-first.
// Latency: first bit on ser_out one cycle after the din handshake; each bit held DIV unpaused cycles.
// Backpressure: din_ready is low for the whole word; pause freezes bit timing and holds outputs.
module seq_serializer #(
  parameter int   WIDTH      = 29,
  parameter int   LEN_W      = 5,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [LEN_W-1:0] len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             pause,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [7:0]       word_cnt
);

  // A 1-bit DIV counter is kept for DIV==1 so the compare logic stays well formed.
  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] loaded, shifted;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic             ser_out_nxt, ser_valid_nxt, done_nxt;
  logic [7:0]       word_cnt_nxt;

  assign din_ready = (state == ST_IDLE);

  // Clamp the requested length and left-align the word so the next bit is always shreg[WIDTH-1].
  always_comb begin
    eff_len = len;
    if ((len == '0) || (len > WIDTH_L)) begin
      eff_len = WIDTH_L;
    end
    loaded  = din << (WIDTH_L - eff_len);
    shifted = shreg << 1;
  end

  // Next-state and registered-output values; everything holds unless a rule below fires.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    div_cnt_nxt   = div_cnt;
    ser_out_nxt   = ser_out;
    ser_valid_nxt = ser_valid;
    done_nxt      = 1'b0;
    word_cnt_nxt  = word_cnt;
    case (state)
      ST_IDLE: begin
        ser_out_nxt   = IDLE_LEVEL;
        ser_valid_nxt = 1'b0;
        if (din_valid) begin
          state_nxt     = ST_SHIFT;
          shreg_nxt     = loaded;
          bit_cnt_nxt   = eff_len;
          div_cnt_nxt   = '0;
          ser_out_nxt   = loaded[WIDTH-1];
          ser_valid_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!pause) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_nxt = '0;
            if (bit_cnt == LEN_W'(1)) begin
              state_nxt     = ST_IDLE;
              ser_out_nxt   = IDLE_LEVEL;
              ser_valid_nxt = 1'b0;
              done_nxt      = 1'b1;
              word_cnt_nxt  = word_cnt + 8'd1;
            end else begin
              bit_cnt_nxt = bit_cnt - LEN_W'(1);
              shreg_nxt   = shifted;
              ser_out_nxt = shifted[WIDTH-1];
            end
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
      done      <= done_nxt;
      word_cnt  <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Purpose: self-checking bench for seq_serializer with a DIV=1 and a DIV=3 instance side by side.
// Latency: a queue-style model predicts ser_out/ser_valid/done/word_cnt every cycle.
// Backpressure: stimulus holds din_valid until din_ready was seen, exercising pause and back-to-back words.
module tb_seq_serializer;

  logic        clk;
  logic        rst;
  logic [28:0] din       [2];
  logic [4:0]  len       [2];
  logic        din_valid [2];
  logic        pause     [2];
  logic        din_ready [2];
  logic        ser_out   [2];
  logic        ser_valid [2];
  logic        done      [2];
  logic [7:0]  word_cnt  [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  seq_serializer #(.WIDTH(29), .LEN_W(5), .DIV(1), .IDLE_LEVEL(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .din(din[0]), .len(len[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .pause(pause[0]), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .done(done[0]), .word_cnt(word_cnt[0]));

  seq_serializer #(.WIDTH(29), .LEN_W(5), .DIV(3), .IDLE_LEVEL(1'b0)) u_d3 (
    .clk(clk), .rst(rst), .din(din[1]), .len(len[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .pause(pause[1]), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .done(done[1]), .word_cnt(word_cnt[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int div_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes a flat list of cycle values (bit repeated DIV times);
  // one entry is consumed per unpaused clock, and an emptied list yields a done cycle.
  bit exp_bits [2][0:99];
  int exp_n    [2];
  int exp_pos  [2];
  bit m_busy   [2];
  bit m_done   [2];
  int m_cnt    [2];

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_busy[s] = 0; m_done[s] = 0; m_cnt[s] = 0; exp_n[s] = 0; exp_pos[s] = 0;
    end
    forever begin
      @(posedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!rst) begin
          m_busy[s] = 0; m_done[s] = 0; m_cnt[s] = 0;
        end else begin
          m_done[s] = 0;
          if (m_busy[s]) begin
            if (!pause[s]) begin
              exp_pos[s]++;
              if (exp_pos[s] == exp_n[s]) begin
                m_busy[s] = 0;
                m_done[s] = 1;
                m_cnt[s]  = (m_cnt[s] + 1) % 256;
              end
            end
          end else if (din_valid[s]) begin
            int l;
            int n;
            l = int'(len[s]);
            if (l == 0 || l > 29) l = 29;
            n = 0;
            for (int i = l - 1; i >= 0; i--) begin
              for (int r = 0; r < div_of(s); r++) begin
                exp_bits[s][n] = din[s][i];
                n++;
              end
            end
            exp_n[s]   = n;
            exp_pos[s] = 0;
            m_busy[s]  = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int s = 0; s < 2; s++) begin
          chk($sformatf("cyc%0d.ser_valid", s), 32'(ser_valid[s]), 32'(m_busy[s]));
          chk($sformatf("cyc%0d.ser_out", s), 32'(ser_out[s]),
              32'(m_busy[s] ? exp_bits[s][exp_pos[s]] : 1'b0));
          chk($sformatf("cyc%0d.done", s), 32'(done[s]), 32'(m_done[s]));
          chk($sformatf("cyc%0d.word_cnt", s), 32'(word_cnt[s]), 32'(m_cnt[s]));
          chk($sformatf("cyc%0d.din_ready", s), 32'(din_ready[s]), 32'(!m_busy[s]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Offer one word and return at the mid-cycle point right after its capture edge.
  task automatic send(input int s, input logic [28:0] d, input logic [4:0] l);
    int guard;
    guard = 0;
    @(negedge clk);
    din[s] = d; len[s] = l; din_valid[s] = 1;
    while (!din_ready[s] && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("send_accept_timeout", 32'(guard < 500), 32'd1);
    @(negedge clk);
    din_valid[s] = 0;
  endtask

  // Send a word and measure the ser_valid run, one reconstructed bit per DIV cycles, and done.
  task automatic run_word(input int s, input logic [28:0] d, input logic [4:0] l,
                          output int cyc, output logic [28:0] w, output int n_done);
    send(s, d, l);
    cyc = 0; w = '0;
    while (ser_valid[s] && cyc < 200) begin
      if (cyc % div_of(s) == 0) w = {w[27:0], ser_out[s]};
      cyc++;
      @(negedge clk);
    end
    n_done = int'(done[s]);
  endtask

  typedef struct {
    int          sel;
    logic [28:0] d;
    logic [4:0]  l;
    int          exp_cyc;
    logic [28:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          cyc;
    int          nd;
    int          c;
    logic [28:0] w;
    logic [10:0] vpat;
    logic [10:0] dpat;

    vecs[0] = '{0, 29'b11110100110110011101111010000, 5'd29, 29, 29'b11110100110110011101111010000};
    vecs[1] = '{1, 29'h1FFFFFF5, 5'd4,  12, 29'h5};
    vecs[2] = '{0, 29'h0ABCDEF1, 5'd0,  29, 29'h0ABCDEF1};
    vecs[3] = '{0, 29'h0ABCDEF1, 5'd31, 29, 29'h0ABCDEF1};
    vecs[4] = '{1, 29'h1FFFFFFF, 5'd1,  3,  29'h1};
    vecs[5] = '{0, 29'h12345678, 5'd16, 16, 29'h5678};
    vecs[6] = '{1, 29'h00000006, 5'd3,  9,  29'h6};

    rst = 0;
    for (int s = 0; s < 2; s++) begin
      din[s] = 29'h1555_5555; len[s] = 5'd7; din_valid[s] = 1; pause[s] = 0;
    end

    // Reset held with din_valid asserted: nothing may be captured.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("rst_hold%0d.din_ready", s), 32'(din_ready[s]), 32'd1);
        chk($sformatf("rst_hold%0d.ser_valid", s), 32'(ser_valid[s]), 32'd0);
        chk($sformatf("rst_hold%0d.ser_out", s), 32'(ser_out[s]), 32'd0);
        chk($sformatf("rst_hold%0d.word_cnt", s), 32'(word_cnt[s]), 32'd0);
      end
    end
    chk_en = 1;
    din_valid[0] = 0; din_valid[1] = 0;
    rst = 1;

    // Table-driven words.
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].sel, vecs[i].d, vecs[i].l, cyc, w, nd);
      chk($sformatf("vec%0d.valid_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d.bits", i), 32'(w), 32'(vecs[i].exp_word));
      chk($sformatf("vec%0d.done", i), 32'(nd), 32'd1);
    end

    // Pause for 5 cycles mid-word on the DIV=3 instance: run stretches from 24 to 29 cycles.
    send(1, 29'h000000A5, 5'd8);
    cyc = 0;
    while (ser_valid[1] && cyc < 200) begin
      cyc++;
      pause[1] = (cyc >= 5 && cyc <= 9);
      @(negedge clk);
    end
    pause[1] = 0;
    chk("pause.valid_cycles", 32'(cyc), 32'd29);

    // Back-to-back: second word offered continuously, accepted on the done cycle.
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    din[0] = 29'b10110; len[0] = 5'd5; din_valid[0] = 1;
    @(negedge clk);
    din[0] = 29'b01101;
    vpat = '0; dpat = '0;
    for (c = 0; c < 11; c++) begin
      vpat = {vpat[9:0], ser_valid[0]};
      dpat = {dpat[9:0], done[0]};
      if (c == 6) din_valid[0] = 0;
      @(negedge clk);
    end
    chk("b2b.valid_pattern", 32'(vpat), 32'(11'b11111011111));
    chk("b2b.done_pattern", 32'(dpat), 32'(11'b00000100000));
    chk("b2b.done2", 32'(done[0]), 32'd1);
    chk("b2b.word_cnt", 32'(word_cnt[0]), 32'd2);

    // Reset at bit 10 of a 29-bit word: word abandoned, no done, count cleared.
    send(0, 29'b11110100110110011101111010000, 5'd29);
    repeat (10) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_mid.ser_valid", 32'(ser_valid[0]), 32'd0);
    chk("rst_mid.done", 32'(done[0]), 32'd0);
    chk("rst_mid.word_cnt", 32'(word_cnt[0]), 32'd0);
    rst = 1;

    // 256 one-bit words back-to-back: count wraps to 0.
    @(negedge clk);
    din[0] = 29'h1; len[0] = 5'd1; din_valid[0] = 1;
    nd = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done[0]) begin
        nd++;
        if (nd == 255) chk("wrap.cnt255", 32'(word_cnt[0]), 32'd255);
        if (nd == 256) begin
          chk("wrap.cnt0", 32'(word_cnt[0]), 32'd0);
          break;
        end
      end
    end
    chk("wrap.done_count", 32'(nd), 32'd256);
    din_valid[0] = 0;
    repeat (4) @(negedge clk);

    // Randomized traffic with random pause on both instances.
    begin
      bit rdy_seen [2];
      rdy_seen[0] = 0; rdy_seen[1] = 0;
      for (int k = 0; k < 2000; k++) begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
          if (din_valid[s] && rdy_seen[s]) din_valid[s] = 0;
          if (!din_valid[s] && ($urandom % 3 == 0)) begin
            din[s] = 29'($urandom);
            len[s] = 5'($urandom % 32);
            din_valid[s] = 1;
          end
          pause[s] = ($urandom % 4 == 0);
          rdy_seen[s] = din_ready[s];
        end
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (din_valid[s] && rdy_seen[s]) din_valid[s] = 0;
        pause[s] = 0;
      end
      // A still-pending offer is allowed to complete before draining.
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
          if (din_valid[s] && rdy_seen[s]) din_valid[s] = 0;
          rdy_seen[s] = din_ready[s];
        end
        if (!din_valid[0] && !din_valid[1] && din_ready[0] && din_ready[1]) break;
      end
      chk("drain.idle0", 32'(din_ready[0]), 32'd1);
      chk("drain.idle1", 32'(din_ready[1]), 32'd1);
    end

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial source stage that sits directly upstream of the Moore sequence detector. Its ser_out drives the detector's in_seq input.
- Accepts a pattern word over a valid/ready handshake. Shifts the low len bits out MSB-first, holding each bit for DIV clock cycles.
- Lets benches and board top-levels replay long test sequences, e.g. the 29-bit pattern 11110100110110011101111010000, without hand-timed stimulus.

Parameters:
- WIDTH, 29, maximum pattern length in bits.
- LEN_W, 5, width of the len port. Must satisfy 2^LEN_W > WIDTH.
- DIV, 1, clock cycles each serial bit is held. Must be >= 1.
- IDLE_LEVEL, 0, value of ser_out when no bit is being sent.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- din  input  WIDTH  pattern word; the bit sent first is din[len-1].
- len  input  LEN_W  number of bits to send; sampled with din.
- din_valid  input  1  a word is offered on din/len.
- din_ready  output  1  the block can accept a word this cycle.
- pause  input  1  freezes bit timing while high.
- ser_out  output  1  serial bit; connects to the detector's in_seq.
- ser_valid  output  1  ser_out currently carries a pattern bit.
- done  output  1  one-cycle pulse after the last bit period ends.
- word_cnt  output  8  number of completed words; wraps 255 -> 0.

Behaviour:
- Reset: clk with rst==0 sets the following, regardless of current state:
  - state=IDLE, ser_out=IDLE_LEVEL, ser_valid=0, done=0, din_ready=1, word_cnt=0.
  - Internal shift register, bit counter and DIV counter cleared.
- Reset mid-SHIFT abandons the word. No done pulse is produced and word_cnt is not incremented.
- State machine: two states, IDLE and SHIFT. din_ready=1 exactly when state==IDLE. All outputs are registered.
- IDLE:
  - ser_out=IDLE_LEVEL, ser_valid=0.
  - Handshake: din_valid && din_ready at edge k captures din/len and moves to SHIFT.
- Effective length L:
  - len==0 gives L=WIDTH.
  - len>WIDTH is clamped to L=WIDTH.
  - Otherwise L=len.
  - Bits din[L-1] down to din[0] are sent; higher din bits are ignored.
- Latency: after capture at edge k, the first bit appears on ser_out with ser_valid=1 at cycle k+1.
- SHIFT:
  - Each bit is held for DIV cycles in which pause==0. A cycle with pause high does not count.
  - While paused, ser_out and ser_valid hold their values.
  - After the L-th bit's final count, the block returns to IDLE on the next edge. In that cycle: ser_out=IDLE_LEVEL, ser_valid=0, done=1, word_cnt increments.
- Timing: with pause low throughout, ser_valid is high for exactly L*DIV consecutive cycles.
- Back-to-back words:
  - A word can be accepted in the first IDLE cycle, the same cycle done=1.
  - This gives a minimum 1-cycle gap between words, with ser_valid=0 during the gap.
- din_valid during SHIFT is ignored (din_ready=0). The source must hold din_valid until it is accepted.
- pause while IDLE has no effect.
- DIV==1: each bit lasts exactly one cycle. The DIV counter logic must still compile cleanly for this case.

Test Plan:
- Reset hold: rst=0 for 3 cycles while din_valid=1 -> din_ready=1, ser_valid=0, ser_out=0, word_cnt=0 throughout. No capture happens until rst=1.
- Full pattern, DIV=1:
  - Stimulus: din=29'b11110100110110011101111010000, len=29.
  - Expected: ser_out reproduces those bits MSB-first on 29 consecutive cycles starting one cycle after the handshake.
  - Expected: done pulses once, word_cnt=1.
  - Expected: the downstream detector shows the same seq_detected pulses as with the hand-timed stimulus.
- Short word, DIV=3:
  - Stimulus: din=0x5 (bits above 4 set to 1), len=4.
  - Expected: ser_out=0,1,0,1, each bit for 3 cycles.
  - Expected: ser_valid high for 12 cycles.
- Length edges:
  - len=0 -> 29 bits sent.
  - len=31 -> 29 bits sent.
  - len=1 with din[0]=1 -> a single 1 for DIV cycles, then done.
- Pause and back-to-back:
  - Stimulus: pause held high 5 cycles mid-word.
  - Expected: ser_valid stretches by exactly 5 cycles, with the bit value held.
  - Stimulus: second word offered continuously.
  - Expected: it is accepted on the done cycle, leaving a 1-cycle gap. word_cnt=2.
- Reset mid-word and wrap:
  - Stimulus: rst=0 at bit 10 of a 29-bit word.
  - Expected: next cycle ser_valid=0, no done, word_cnt=0.
  - Stimulus: 256 words of len=1.
  - Expected: word_cnt wraps to 0.
